// File: rtl/jk_mod_counter.sv
// Modulo-MODULUS up/down counter built from JK flip-flop stages.
// The next count is reduced to per-bit J/K excitation, and only that excitation updates the state.
module jk_mod_counter #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             EN,
   input  logic             UP,
   input  logic             LD,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] J,
   output logic [WIDTH-1:0] K,
   output logic [WIDTH-1:0] Q,
   output logic             TC,
   output logic             WRAP,
   output logic             LDERR
);

   // One extra bit so that MODULUS == 2**WIDTH still compares correctly against D.
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH-1:0] TERM    = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] n_next;
   logic             ld_bad;
   logic             wrap_hit;
   logic             wrap_reg;
   logic             lderr_reg;

   assign ld_bad = ({1'b0, D} >= MOD_EXT);

   always_comb begin
      n_next = Q;
      if (LD) begin
         n_next = ld_bad ? '0 : D;
      end else if (EN) begin
         if (UP) begin
            n_next = (Q == TERM) ? '0 : Q + WIDTH'(1);
         end else begin
            n_next = (Q == '0) ? TERM : Q - WIDTH'(1);
         end
      end
   end

   assign J = ~Q & n_next;
   assign K = Q & ~n_next;

   assign wrap_hit = EN & ~LD & ((UP & (Q == TERM)) | (~UP & (Q == '0)));
   assign TC       = wrap_hit;

   // Each state bit is its own JK stage, updated only by the characteristic equation.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stage
         logic q_bit;
         always_ff @(posedge CLK) begin
            if (!RST_N) begin
               q_bit <= 1'b0;
            end else begin
               q_bit <= (J[gi] & ~q_bit) | (~K[gi] & q_bit);
            end
         end
         assign Q[gi] = q_bit;
      end
   endgenerate

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         wrap_reg  <= 1'b0;
         lderr_reg <= 1'b0;
      end else begin
         wrap_reg  <= wrap_hit;
         lderr_reg <= LD & ld_bad;
      end
   end

   assign WRAP  = wrap_reg;
   assign LDERR = lderr_reg;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Scoreboard bench for jk_mod_counter (WIDTH=4, MODULUS=10) with external JK cells fed from J/K.
module tb_jk_mod_counter;

   localparam int W   = 4;
   localparam int MOD = 10;

   logic         CLK;
   logic         RST_N;
   logic         EN;
   logic         UP;
   logic         LD;
   logic [W-1:0] D;
   logic [W-1:0] J;
   logic [W-1:0] K;
   logic [W-1:0] Q;
   logic         TC;
   logic         WRAP;
   logic         LDERR;

   typedef struct {
      logic [W-1:0] q;
      logic         wrap;
      logic         lderr;
   } exp_t;

   exp_t         sb[$];
   int           m_q;
   logic [W-1:0] exp_j;
   logic [W-1:0] exp_k;
   logic         exp_tc;
   logic [W-1:0] ext_q;
   int           errors;
   int           checks;

   jk_mod_counter #(.WIDTH(W), .MODULUS(MOD)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .EN    (EN),
      .UP    (UP),
      .LD    (LD),
      .D     (D),
      .J     (J),
      .K     (K),
      .Q     (Q),
      .TC    (TC),
      .WRAP  (WRAP),
      .LDERR (LDERR)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // External JK flip-flop bank driven by the block's exported excitation.
   always @(posedge CLK) begin
      for (int i = 0; i < W; i++) begin
         if (!RST_N) ext_q[i] <= 1'b0;
         else        ext_q[i] <= (J[i] & ~ext_q[i]) | (~K[i] & ext_q[i]);
      end
   end

   // Apply one cycle of stimulus and push the reference outcome for the coming edge.
   task automatic drive(input logic rst, input logic en, input logic up,
                        input logic ld, input logic [W-1:0] d);
      exp_t e;
      int   n;
      logic [W-1:0] cur;
      RST_N = rst; EN = en; UP = up; LD = ld; D = d;
      e.wrap  = 1'b0;
      e.lderr = 1'b0;
      if (!rst) begin
         n = 0;
      end else if (ld) begin
         if (int'(d) < MOD) n = int'(d);
         else begin
            n = 0;
            e.lderr = 1'b1;
         end
      end else if (en && up) begin
         if (m_q == MOD - 1) begin
            n = 0;
            e.wrap = 1'b1;
         end else n = m_q + 1;
      end else if (en) begin
         if (m_q == 0) begin
            n = MOD - 1;
            e.wrap = 1'b1;
         end else n = m_q - 1;
      end else begin
         n = m_q;
      end
      cur    = W'(m_q);
      exp_tc = en & ~ld & ((up & (m_q == MOD - 1)) | (~up & (m_q == 0)));
      exp_j  = rst ? (~cur & W'(n)) : (~cur & W'(m_q));
      exp_k  = rst ? (cur & ~W'(n)) : (cur & ~W'(m_q));
      e.q    = W'(n);
      m_q    = n;
      sb.push_back(e);
      $display("txn t=%0t rst_n=%b en=%b up=%b ld=%b d=%0d -> exp q=%0d wrap=%b lderr=%b",
               $time, rst, en, up, ld, d, e.q, e.wrap, e.lderr);
      #1;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
         tick();
         e = sb.pop_front();
         checks++;
         if ({Q, WRAP, LDERR} !== {e.q, e.wrap, e.lderr}) begin
            errors++;
            $display("FAIL reset_state: got Q=%0d WRAP=%b LDERR=%b required Q=%0d WRAP=%b LDERR=%b",
                     Q, WRAP, LDERR, e.q, e.wrap, e.lderr);
         end
      end
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd7);
         checks++;
         if ({J, K, TC} !== {4'd0, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL hold_excitation: got J=%b K=%b TC=%b required J=0000 K=0000 TC=0", J, K, TC);
         end
         tick();
         e = sb.pop_front();
         checks++;
         if ({Q, WRAP, LDERR} !== {4'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL hold_state: got Q=%0d WRAP=%b LDERR=%b required Q=0 WRAP=0 LDERR=0",
                     Q, WRAP, LDERR);
         end
      end
   endtask

   task automatic test_up_count();
      exp_t e;
      int   seq[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
      for (int i = 0; i < 12; i++) begin
         drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
         checks++;
         if (TC !== (m_q == 0 && i == 9)) begin
            errors++;
            $display("FAIL up_tc[%0d]: got TC=%b required %b", i, TC, (i == 9));
         end
         if (i == 7) begin
            checks++;
            if ({J, K} !== {4'b1000, 4'b0111}) begin
               errors++;
               $display("FAIL up_jk_at7: got J=%b K=%b required J=1000 K=0111", J, K);
            end
         end
         tick();
         e = sb.pop_front();
         checks++;
         if ({Q, WRAP, LDERR} !== {e.q, e.wrap, e.lderr} || int'(Q) != seq[i] || WRAP !== (i == 9)) begin
            errors++;
            $display("FAIL up_step[%0d]: got Q=%0d WRAP=%b LDERR=%b required Q=%0d WRAP=%b LDERR=0",
                     i, Q, WRAP, LDERR, seq[i], (i == 9));
         end
      end
   endtask

   task automatic test_down_wrap();
      exp_t e;
      int   seq[3] = '{9, 8, 7};
      drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
      tick();
      e = sb.pop_front();
      checks++;
      if ({Q, WRAP, LDERR} !== {4'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL down_preload: got Q=%0d WRAP=%b LDERR=%b required Q=0 WRAP=0 LDERR=0",
                  Q, WRAP, LDERR);
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
         if (i == 0) begin
            checks++;
            if ({J, K, TC} !== {4'b1001, 4'b0000, 1'b1}) begin
               errors++;
               $display("FAIL down_jk_at0: got J=%b K=%b TC=%b required J=1001 K=0000 TC=1", J, K, TC);
            end
         end
         tick();
         e = sb.pop_front();
         checks++;
         if ({Q, WRAP, LDERR} !== {e.q, e.wrap, e.lderr} || int'(Q) != seq[i] || WRAP !== (i == 0)) begin
            errors++;
            $display("FAIL down_step[%0d]: got Q=%0d WRAP=%b required Q=%0d WRAP=%b",
                     i, Q, WRAP, seq[i], (i == 0));
         end
      end
   endtask

   task automatic test_load();
      exp_t       e;
      logic [3:0] dv[5]  = '{4'd5, 4'd12, 4'd0, 4'd9, 4'd15};
      logic [3:0] qv[5]  = '{4'd5, 4'd0, 4'd0, 4'd9, 4'd0};
      logic       lev[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b1, 1'b1, 1'b1, dv[i]);
         checks++;
         if (TC !== 1'b0 || (J & K) !== 4'd0) begin
            errors++;
            $display("FAIL load_comb[%0d]: got TC=%b J=%b K=%b required TC=0 and disjoint J/K", i, TC, J, K);
         end
         if (i == 2) begin
            checks++;
            if ({J, K} !== 8'd0) begin
               errors++;
               $display("FAIL load_same_jk: got J=%b K=%b required J=0000 K=0000", J, K);
            end
         end
         tick();
         e = sb.pop_front();
         checks++;
         if ({Q, WRAP, LDERR} !== {e.q, e.wrap, e.lderr} || Q !== qv[i] || LDERR !== lev[i] || WRAP !== 1'b0) begin
            errors++;
            $display("FAIL load_step[%0d]: got Q=%0d WRAP=%b LDERR=%b required Q=%0d WRAP=0 LDERR=%b",
                     i, Q, WRAP, LDERR, qv[i], lev[i]);
         end
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      tick();
      e = sb.pop_front();
      checks++;
      if ({Q, WRAP, LDERR} !== {4'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL lderr_clear: got Q=%0d WRAP=%b LDERR=%b required Q=0 WRAP=0 LDERR=0", Q, WRAP, LDERR);
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
         tick();
         e = sb.pop_front();
         checks++;
         if ({Q, WRAP, LDERR} !== {e.q, e.wrap, e.lderr}) begin
            errors++;
            $display("FAIL mid_count[%0d]: got Q=%0d required Q=%0d", i, Q, e.q);
         end
      end
      drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd3);
      tick();
      e = sb.pop_front();
      checks++;
      if ({Q, WRAP, LDERR} !== {4'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL mid_reset: got Q=%0d WRAP=%b LDERR=%b required Q=0 WRAP=0 LDERR=0", Q, WRAP, LDERR);
      end
      for (int i = 1; i <= 2; i++) begin
         drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
         tick();
         e = sb.pop_front();
         checks++;
         if ({Q, WRAP, LDERR} !== {e.q, e.wrap, e.lderr} || int'(Q) != i) begin
            errors++;
            $display("FAIL mid_resume[%0d]: got Q=%0d required Q=%0d", i, Q, i);
         end
      end
   endtask

   task automatic test_cross_check();
      exp_t e;
      for (int i = 0; i < 1000; i++) begin
         drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)));
         checks++;
         if ((J & K) !== 4'd0 || J !== exp_j || K !== exp_k || TC !== exp_tc) begin
            errors++;
            $display("FAIL xc_excitation[%0d]: got J=%b K=%b TC=%b required J=%b K=%b TC=%b",
                     i, J, K, TC, exp_j, exp_k, exp_tc);
         end
         tick();
         e = sb.pop_front();
         checks++;
         if ({Q, WRAP, LDERR} !== {e.q, e.wrap, e.lderr} || ext_q !== Q || int'(Q) >= MOD) begin
            errors++;
            $display("FAIL xc_state[%0d]: got Q=%0d ext=%0d WRAP=%b LDERR=%b required Q=%0d WRAP=%b LDERR=%b",
                     i, Q, ext_q, WRAP, LDERR, e.q, e.wrap, e.lderr);
         end
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      m_q    = 0;
      RST_N  = 1'b0;
      EN     = 1'b0;
      UP     = 1'b0;
      LD     = 1'b0;
      D      = '0;
      test_reset();
      test_up_count();
      test_down_wrap();
      test_load();
      test_reset_mid();
      test_cross_check();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
